btb_assoc: RTL and testbench

BTB_ASSOC -- requirements
Module: btb_assoc

---
 rtl/btb_pkg.sv | 27 ++
 rtl/btb_sat_ctr.sv | 23 ++
 rtl/btb_assoc.sv | 140 ++++++++++++++
 tb/tb_btb_assoc.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/btb_pkg.sv
// Shared types and defaults for the set-associative branch target buffer.
// Holds the 2-bit direction counter encoding, the per-entry storage record
// and the default geometry used by btb_assoc.
package btb_pkg;

    localparam int BTB_SETS  = 8;
    localparam int BTB_WAYS  = 2;

    // Widest tag occurs at the smallest legal SETS (2 -> 1 index bit).
    // Narrower configurations zero-extend their tag into this field.
    localparam int TAG_MAX_W = 29;

    typedef enum logic [1:0] {
        STRONG_NT = 2'd0,
        WEAK_NT   = 2'd1,
        WEAK_T    = 2'd2,
        STRONG_T  = 2'd3
    } ctr_e;

    typedef struct packed {
        logic                 valid;
        logic [TAG_MAX_W-1:0] tag;
        logic [31:0]          target;
        ctr_e                 ctr;
    } btb_entry_t;

endpackage

// File: rtl/btb_sat_ctr.sv
// Next-state logic for a 2-bit saturating direction counter.
// Ports:
//   cnt_i   - current counter value
//   taken_i - resolved direction (1 = taken)
//   cnt_o   - counter value after applying the outcome
module btb_sat_ctr
    import btb_pkg::*;
(
    input  logic [1:0] cnt_i,
    input  logic       taken_i,
    output logic [1:0] cnt_o
);

    always_comb begin
        cnt_o = cnt_i;
        if (taken_i && (cnt_i != 2'(STRONG_T))) begin
            cnt_o = cnt_i + 2'd1;
        end else if (!taken_i && (cnt_i != 2'(STRONG_NT))) begin
            cnt_o = cnt_i - 2'd1;
        end
    end

endmodule

// File: rtl/btb_assoc.sv
// Set-associative branch target buffer with flip-flop storage.
// Lookup is combinational from lookup_pc; updates from the mem stage land
// on the rising edge of CLK, so a same-cycle lookup sees pre-update data.
// Ports:
//   CLK, nRST          - clock, async active-low reset
//   lookup_pc          - fetch PC
//   hit, predict_taken - lookup result; predict_taken = hit & counter MSB
//   predict_target     - target of the hitting way, 0 on miss
//   upd_en, upd_pc, upd_target, upd_taken - resolved branch update
//   flush              - synchronous invalidate (beats a same-cycle update)
module btb_assoc
    import btb_pkg::*;
#(
    parameter int SETS = BTB_SETS,
    parameter int WAYS = BTB_WAYS
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic [31:0] lookup_pc,
    output logic        hit,
    output logic        predict_taken,
    output logic [31:0] predict_target,
    input  logic        upd_en,
    input  logic [31:0] upd_pc,
    input  logic [31:0] upd_target,
    input  logic        upd_taken,
    input  logic        flush
);

    localparam int IDX_W = $clog2(SETS);
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    btb_entry_t mem_q [SETS][WAYS];

    logic [IDX_W-1:0]     lk_idx;
    logic [TAG_MAX_W-1:0] lk_tag;
    logic [IDX_W-1:0]     up_idx;
    logic [TAG_MAX_W-1:0] up_tag;

    assign lk_idx = lookup_pc[IDX_W+1:2];
    assign lk_tag = TAG_MAX_W'(lookup_pc[31:IDX_W+2]);
    assign up_idx = upd_pc[IDX_W+1:2];
    assign up_tag = TAG_MAX_W'(upd_pc[31:IDX_W+2]);

    // Byte offset within the instruction word never selects an entry.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{lookup_pc[1:0], upd_pc[1:0]};

    // Ways are scanned high to low so the lowest matching way is the last
    // writer and therefore wins if duplicates were ever forced in.
    always_comb begin
        hit            = 1'b0;
        predict_taken  = 1'b0;
        predict_target = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (mem_q[lk_idx][w].valid && (mem_q[lk_idx][w].tag == lk_tag)) begin
                hit            = 1'b1;
                predict_taken  = mem_q[lk_idx][w].ctr[1];
                predict_target = mem_q[lk_idx][w].target;
            end
        end
    end

    logic             up_hit;
    logic [WAY_W-1:0] up_hit_way;
    logic             up_inv;
    logic [WAY_W-1:0] up_inv_way;
    logic [WAY_W-1:0] ptr_cur;
    logic [WAY_W-1:0] alloc_way;
    logic [1:0]       ctr_nxt;

    always_comb begin
        up_hit     = 1'b0;
        up_hit_way = '0;
        up_inv     = 1'b0;
        up_inv_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (mem_q[up_idx][w].valid && (mem_q[up_idx][w].tag == up_tag)) begin
                up_hit     = 1'b1;
                up_hit_way = WAY_W'(w);
            end
            if (!mem_q[up_idx][w].valid) begin
                up_inv     = 1'b1;
                up_inv_way = WAY_W'(w);
            end
        end
    end

    assign alloc_way = up_inv ? up_inv_way : ptr_cur;

    btb_sat_ctr u_sat_ctr (
        .cnt_i   (mem_q[up_idx][up_hit_way].ctr),
        .taken_i (upd_taken),
        .cnt_o   (ctr_nxt)
    );

    generate
        if (WAYS > 1) begin : g_ptr
            logic [WAY_W-1:0] ptr_q [SETS];

            // Only evictions of a valid way rotate the victim pointer.
            always_ff @(posedge CLK or negedge nRST) begin
                if (!nRST) begin
                    for (int s = 0; s < SETS; s++) ptr_q[s] <= '0;
                end else if (flush) begin
                    for (int s = 0; s < SETS; s++) ptr_q[s] <= '0;
                end else if (upd_en && upd_taken && !up_hit && !up_inv) begin
                    ptr_q[up_idx] <= ptr_q[up_idx] + WAY_W'(1);
                end
            end

            assign ptr_cur = ptr_q[up_idx];
        end else begin : g_noptr
            assign ptr_cur = '0;
        end
    endgenerate

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) mem_q[s][w] <= '0;
            end
        end else if (flush) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) mem_q[s][w].valid <= 1'b0;
            end
        end else if (upd_en) begin
            if (up_hit) begin
                mem_q[up_idx][up_hit_way].ctr <= ctr_e'(ctr_nxt);
                if (upd_taken) mem_q[up_idx][up_hit_way].target <= upd_target;
            end else if (upd_taken) begin
                mem_q[up_idx][alloc_way].valid  <= 1'b1;
                mem_q[up_idx][alloc_way].tag    <= up_tag;
                mem_q[up_idx][alloc_way].target <= upd_target;
                mem_q[up_idx][alloc_way].ctr    <= WEAK_T;
            end
        end
    end

endmodule

// File: tb/tb_btb_assoc.sv
module tb_btb_assoc;

    logic        CLK;
    logic        nRST;
    logic [31:0] lookup_pc;
    logic        hit;
    logic        predict_taken;
    logic [31:0] predict_target;
    logic        upd_en;
    logic [31:0] upd_pc;
    logic [31:0] upd_target;
    logic        upd_taken;
    logic        flush;

    btb_assoc #(.SETS(8), .WAYS(2)) dut (
        .CLK            (CLK),
        .nRST           (nRST),
        .lookup_pc      (lookup_pc),
        .hit            (hit),
        .predict_taken  (predict_taken),
        .predict_target (predict_target),
        .upd_en         (upd_en),
        .upd_pc         (upd_pc),
        .upd_target     (upd_target),
        .upd_taken      (upd_taken),
        .flush          (flush)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        h;
        logic        pt;
        logic [31:0] tgt;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Monitor: the lookup result is sampled mid-cycle, away from the edge.
    always @(negedge CLK) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks = checks + 1;
            if (hit !== e.h || predict_taken !== e.pt || predict_target !== e.tgt) begin
                failures = failures + 1;
                $display("FAIL %s: got hit=%0b pt=%0b tgt=%h, expected hit=%0b pt=%0b tgt=%h",
                         e.name, hit, predict_taken, predict_target, e.h, e.pt, e.tgt);
            end
        end
    end

    task automatic check_now(input logic eh, input logic ep, input logic [31:0] et,
                             input string nm);
        checks = checks + 1;
        if (hit !== eh || predict_taken !== ep || predict_target !== et) begin
            failures = failures + 1;
            $display("FAIL %s: got hit=%0b pt=%0b tgt=%h, expected hit=%0b pt=%0b tgt=%h",
                     nm, hit, predict_taken, predict_target, eh, ep, et);
        end
    endtask

    // Drives one cycle of inputs just after the rising edge and queues the
    // lookup result expected for the state seen in that cycle.
    task automatic step(input logic rst_n, input logic [31:0] lpc,
                        input logic uen, input logic [31:0] upc,
                        input logic [31:0] utgt, input logic utk, input logic fl,
                        input logic eh, input logic ep, input logic [31:0] et,
                        input string nm);
        @(posedge CLK);
        #1;
        nRST       = rst_n;
        lookup_pc  = lpc;
        upd_en     = uen;
        upd_pc     = upc;
        upd_target = utgt;
        upd_taken  = utk;
        flush      = fl;
        exp_q.push_back('{eh, ep, et, nm});
    endtask

    task automatic look(input logic [31:0] lpc, input logic eh, input logic ep,
                        input logic [31:0] et, input string nm);
        step(1'b1, lpc, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, eh, ep, et, nm);
    endtask

    task automatic upd(input logic [31:0] lpc, input logic [31:0] upc,
                       input logic [31:0] utgt, input logic utk,
                       input logic eh, input logic ep, input logic [31:0] et,
                       input string nm);
        step(1'b1, lpc, 1'b1, upc, utgt, utk, 1'b0, eh, ep, et, nm);
    endtask

    initial begin
        nRST       = 1'b0;
        lookup_pc  = 32'h40;
        upd_en     = 1'b0;
        upd_pc     = 32'h0;
        upd_target = 32'h0;
        upd_taken  = 1'b0;
        flush      = 1'b0;

        #1;
        check_now(1'b0, 1'b0, 32'h0, "reset_state");

        step(1'b0, 32'h40, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, "in_reset");
        look(32'h40, 1'b0, 1'b0, 32'h0, "after_reset_miss");

        // first allocation with a same-cycle lookup of the same entry
        upd (32'h40, 32'h40, 32'h100, 1'b1, 1'b0, 1'b0, 32'h0,   "alloc_same_cycle_miss");
        look(32'h40, 1'b1, 1'b1, 32'h100, "alloc_visible");
        look(32'h44, 1'b0, 1'b0, 32'h0,   "other_set_miss");

        // counter 2 -> 1 -> 0 -> 0 -> 1 -> 2; target untouched by not-taken
        upd (32'h40, 32'h40, 32'h999, 1'b0, 1'b1, 1'b1, 32'h100, "nt1_pre_ctr2");
        upd (32'h40, 32'h40, 32'h999, 1'b0, 1'b1, 1'b0, 32'h100, "nt2_pre_ctr1");
        upd (32'h40, 32'h40, 32'h999, 1'b0, 1'b1, 1'b0, 32'h100, "nt3_pre_ctr0");
        upd (32'h40, 32'h40, 32'h100, 1'b1, 1'b1, 1'b0, 32'h100, "t1_pre_ctr0_sat");
        upd (32'h40, 32'h40, 32'h100, 1'b1, 1'b1, 1'b0, 32'h100, "t2_pre_ctr1");
        look(32'h40, 1'b1, 1'b1, 32'h100, "ctr2_taken_again");

        // taken hit rewrites target; saturation at 3
        upd (32'h40, 32'h40, 32'h140, 1'b1, 1'b1, 1'b1, 32'h100, "retarget_pre");
        upd (32'h40, 32'h40, 32'h140, 1'b1, 1'b1, 1'b1, 32'h140, "retarget_visible_ctr3");
        upd (32'h40, 32'h40, 32'h0,   1'b0, 1'b1, 1'b1, 32'h140, "sat3_nt_pre");
        upd (32'h40, 32'h40, 32'h0,   1'b0, 1'b1, 1'b1, 32'h140, "ctr2_nt_pre");
        look(32'h40, 1'b1, 1'b0, 32'h140, "ctr1_not_taken");

        // not-taken miss allocates nothing
        upd (32'h60, 32'h60, 32'h200, 1'b0, 1'b0, 1'b0, 32'h0, "nt_miss_no_alloc_pre");
        look(32'h60, 1'b0, 1'b0, 32'h0, "nt_miss_no_alloc");

        // fill and evict set 0
        upd (32'h60, 32'h60, 32'h200, 1'b1, 1'b0, 1'b0, 32'h0,   "fill_way1");
        upd (32'h60, 32'h80, 32'h300, 1'b1, 1'b1, 1'b1, 32'h200, "evict_way0_pre");
        look(32'h40, 1'b0, 1'b0, 32'h0,   "evicted_40_miss");
        look(32'h60, 1'b1, 1'b1, 32'h200, "kept_60_hit");
        look(32'h80, 1'b1, 1'b1, 32'h300, "new_80_hit");
        upd (32'h80, 32'hA0, 32'h400, 1'b1, 1'b1, 1'b1, 32'h300, "evict_way1_pre");
        look(32'h60, 1'b0, 1'b0, 32'h0,   "evicted_60_miss");
        look(32'hA0, 1'b1, 1'b1, 32'h400, "new_A0_hit");
        upd (32'h80, 32'hC0, 32'h500, 1'b1, 1'b1, 1'b1, 32'h300, "evict_way0_again_pre");
        look(32'h80, 1'b0, 1'b0, 32'h0,   "evicted_80_miss");

        // flush beats a same-cycle update and clears the pointer
        step(1'b1, 32'hC0, 1'b1, 32'h40, 32'h500, 1'b1, 1'b1, 1'b1, 1'b1, 32'h500, "flush_pre");
        look(32'h40, 1'b0, 1'b0, 32'h0, "flush_drops_update");
        look(32'hC0, 1'b0, 1'b0, 32'h0, "flush_clears_C0");
        look(32'hA0, 1'b0, 1'b0, 32'h0, "flush_clears_A0");
        upd (32'h0, 32'h40, 32'h100, 1'b1, 1'b0, 1'b0, 32'h0, "refill_40");
        upd (32'h0, 32'h60, 32'h200, 1'b1, 1'b0, 1'b0, 32'h0, "refill_60");
        upd (32'h0, 32'h80, 32'h300, 1'b1, 1'b0, 1'b0, 32'h0, "refill_80");
        look(32'h40, 1'b0, 1'b0, 32'h0,   "ptr_reset_evicts_way0");
        look(32'h60, 1'b1, 1'b1, 32'h200, "ptr_reset_keeps_60");

        // async reset between edges, with an update in flight
        step(1'b0, 32'h60, 1'b1, 32'h44, 32'h700, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, "async_reset_miss");
        #1;
        check_now(1'b0, 1'b0, 32'h0, "async_reset_immediate");
        look(32'h60, 1'b0, 1'b0, 32'h0, "after_reset_60_miss");
        look(32'h44, 1'b0, 1'b0, 32'h0, "reset_drops_update");

        @(posedge CLK);
        #1;
        upd_en = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
